// File: rtl/axi_rd.sv
// AXI-3 read master helper: one INCR burst per enable, beats gathered into a wide
// data register, OK/error status derived from RRESP, beat count and RLAST position.
module axi_rd #(
  parameter int AXI_RD_ID_WIDTH      = 8,
  parameter int AXI_RD_ADDR_WIDTH    = 32,
  parameter int AXI_RD_BUS_WIDTH     = 32,
  parameter int AXI_RD_MAX_BURST_LEN = 1
) (
  input  logic                                           clock,
  input  logic                                           reset_n,
  input  logic                                           enable,
  input  logic [AXI_RD_ID_WIDTH-1:0]                     id,
  input  logic [AXI_RD_ADDR_WIDTH-1:0]                   addr,
  input  logic [3:0]                                     burst_len,
  input  logic [2:0]                                     burst_size,
  output logic [AXI_RD_MAX_BURST_LEN*AXI_RD_BUS_WIDTH-1:0] data,
  output logic [1:0]                                     status,
  output logic [AXI_RD_ID_WIDTH-1:0]                     ar_id,
  output logic [AXI_RD_ADDR_WIDTH-1:0]                   ar_addr,
  output logic [3:0]                                     ar_len,
  output logic [2:0]                                     ar_size,
  output logic [1:0]                                     ar_burst,
  output logic [2:0]                                     ar_prot,
  output logic                                           ar_valid,
  input  logic                                           ar_ready,
  input  logic [AXI_RD_ID_WIDTH-1:0]                     r_id,
  input  logic [AXI_RD_BUS_WIDTH-1:0]                    r_data,
  input  logic [1:0]                                     r_resp,
  input  logic                                           r_last,
  input  logic                                           r_valid,
  output logic                                           r_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_OK    = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  logic [1:0] state;
  logic [3:0] beat;
  logic       err;
  logic       r_hs;

  assign ar_burst = 2'b01;
  assign ar_prot  = 3'b000;
  assign r_hs     = r_valid && r_ready;

  // r_id is left to the interconnect arbiter; this master trusts ordering.
  logic unused_r_id;
  assign unused_r_id = ^r_id;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      status   <= ST_READY;
      ar_valid <= 1'b0;
      r_ready  <= 1'b0;
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      beat     <= '0;
      err      <= 1'b0;
      data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            ar_id    <= id;
            ar_addr  <= addr;
            ar_len   <= burst_len;
            ar_size  <= burst_size;
            beat     <= '0;
            err      <= 1'b0;
            data     <= '0;
            ar_valid <= 1'b1;
            status   <= ST_WAIT;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (ar_valid && ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            // Beats past the storage depth are consumed but dropped.
            for (int n = 0; n < AXI_RD_MAX_BURST_LEN; n++) begin
              if (beat == 4'(n)) data[n*AXI_RD_BUS_WIDTH +: AXI_RD_BUS_WIDTH] <= r_data;
            end
            beat <= beat + 4'd1;
            // Reaching ar_len without RLAST means the slave overran the burst.
            err  <= err | r_resp[1] | (!r_last && (beat == ar_len));
            if (r_last) begin
              r_ready <= 1'b0;
              state   <= DONE;
              status  <= (err || r_resp[1] || (beat != ar_len)) ? ST_ERR : ST_OK;
            end
          end
        end
        default: begin
          if (!enable) begin
            status <= ST_READY;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd.sv
// Scoreboard bench for axi_rd: directed bursts, expected AR fields and final
// data/status queued at issue time and checked by an independent monitor.
module tb_axi_rd;

  localparam int IDW = 8;
  localparam int AW  = 32;
  localparam int BW  = 32;
  localparam int MAX = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [IDW-1:0]   id = '0;
  logic [AW-1:0]    addr = '0;
  logic [3:0]       burst_len = '0;
  logic [2:0]       burst_size = '0;
  logic [MAX*BW-1:0] data;
  logic [1:0]       status;
  logic [IDW-1:0]   ar_id;
  logic [AW-1:0]    ar_addr;
  logic [3:0]       ar_len;
  logic [2:0]       ar_size;
  logic [1:0]       ar_burst;
  logic [2:0]       ar_prot;
  logic             ar_valid;
  logic             ar_ready = 1'b0;
  logic [IDW-1:0]   r_id = '0;
  logic [BW-1:0]    r_data = '0;
  logic [1:0]       r_resp = '0;
  logic             r_last = 1'b0;
  logic             r_valid = 1'b0;
  logic             r_ready;

  axi_rd #(
    .AXI_RD_ID_WIDTH(IDW), .AXI_RD_ADDR_WIDTH(AW),
    .AXI_RD_BUS_WIDTH(BW), .AXI_RD_MAX_BURST_LEN(MAX)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .id(id), .addr(addr),
    .burst_len(burst_len), .burst_size(burst_size), .data(data), .status(status),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [MAX*BW-1:0] d;
    logic [1:0]        s;
  } done_t;

  done_t        done_q[$];
  logic [63:0]  ar_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [1:0]   prev_status = 2'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: AR handshakes and DONE entries are checked against the queues.
  always @(negedge clock) begin
    if (reset_n) begin
      if (ar_valid && ar_ready) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 128'd1, 128'd0);
        else chk("ar_fields", {64'd0, 12'd0, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot},
                 {64'd0, ar_q.pop_front()});
      end
      if (status >= 2'd2 && prev_status == 2'd1) begin
        if (done_q.size() == 0) chk("done_unexpected", 128'd1, 128'd0);
        else begin
          done_t e;
          e = done_q.pop_front();
          chk("done_data", data, e.d);
          chk("done_status", {126'd0, status}, {126'd0, e.s});
        end
      end
    end
    prev_status = status;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_ar(input logic [7:0] tid, input logic [31:0] taddr, input logic [3:0] tlen);
    ar_q.push_back({12'd0, tid, taddr, tlen, 3'd2, 2'b01, 3'b000});
  endtask

  // Beat k carries base + k*step; err_at beat gets SLVERR, others ok_resp.
  task automatic run_txn(input logic [7:0] tid, input logic [31:0] taddr, input logic [3:0] tlen,
                         input int ar_dly, input int last_at, input int err_at, input int gap,
                         input logic [1:0] ok_resp, input logic [31:0] base, input logic [31:0] step,
                         input int hold);
    bit hs, ok;
    push_ar(tid, taddr, tlen);
    enable = 1'b1; id = tid; addr = taddr; burst_len = tlen; burst_size = 3'd2;
    tick();
    chk("start_status", {126'd0, status}, 128'd1);
    chk("start_ar_valid", {127'd0, ar_valid}, 128'd1);
    id = ~tid; addr = 32'hFFFF_FFFF; burst_len = 4'hF; burst_size = 3'd0;
    for (int i = 0; i < ar_dly; i++) begin
      tick();
      chk("ar_valid_held", {127'd0, ar_valid}, 128'd1);
    end
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    chk("after_ar_r_ready", {127'd0, r_ready}, 128'd1);
    chk("after_ar_ar_valid", {127'd0, ar_valid}, 128'd0);
    for (int k = 0; k <= last_at; k++) begin
      if (gap > 0 && (k % 2) == 1) begin
        r_valid = 1'b0;
        repeat (gap) tick();
      end
      r_valid = 1'b1;
      r_data  = base + 32'(k) * step;
      r_resp  = (k == err_at) ? 2'b10 : ok_resp;
      r_last  = (k == last_at);
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        hs = r_ready;
        tick();
        if (hs) begin ok = 1'b1; break; end
      end
      if (!ok) chk("beat_timeout", 128'd0, 128'd1);
    end
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
    chk("after_last_r_ready", {127'd0, r_ready}, 128'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("done_hold_no_ar", {127'd0, ar_valid}, 128'd0);
    end
    enable = 1'b0;
    tick();
    chk("ack_status", {126'd0, status}, 128'd0);
  endtask

  task automatic push_done(input logic [127:0] d, input logic [1:0] s);
    done_t e;
    e.d = d;
    e.s = s;
    done_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_ar_valid", {127'd0, ar_valid}, 128'd0);
    chk("rst_r_ready", {127'd0, r_ready}, 128'd0);
    chk("rst_status", {126'd0, status}, 128'd0);
    chk("rst_data", data, 128'd0);
    chk("rst_ar_burst", {126'd0, ar_burst}, 128'd1);
    reset_n = 1'b1;
    tick();

    // Single beat, minimum latency.
    push_done(128'h00000000_00000000_00000000_DEADBEEF, 2'd2);
    run_txn(8'h5A, 32'h0000_1000, 4'd0, 0, 0, -1, 0, 2'b00, 32'hDEADBEEF, 32'd0, 2);

    // Four beats, slow AR ready, gaps on R.
    push_done(128'h00000044_00000033_00000022_00000011, 2'd2);
    run_txn(8'h21, 32'h0000_2000, 4'd3, 5, 3, -1, 2, 2'b00, 32'h11, 32'h11, 1);

    // SLVERR on beat 2.
    push_done(128'h000000A3_000000A2_000000A1_000000A0, 2'd3);
    run_txn(8'h33, 32'h0000_3000, 4'd3, 1, 3, 2, 0, 2'b00, 32'hA0, 32'h1, 1);

    // Early RLAST on beat 1.
    push_done(128'h00000000_00000000_000000B1_000000B0, 2'd3);
    run_txn(8'h44, 32'h0000_4000, 4'd3, 0, 1, -1, 0, 2'b00, 32'hB0, 32'h1, 1);

    // Late RLAST: len=1 but last on beat 3.
    push_done(128'h000000C3_000000C2_000000C1_000000C0, 2'd3);
    run_txn(8'h55, 32'h0000_5000, 4'd1, 0, 3, -1, 0, 2'b00, 32'hC0, 32'h1, 1);

    // Burst longer than storage: beats 4,5 dropped; long DONE hold.
    push_done(128'h000000D3_000000D2_000000D1_000000D0, 2'd2);
    run_txn(8'h66, 32'h0000_6000, 4'd5, 0, 5, -1, 0, 2'b00, 32'hD0, 32'h1, 10);

    // EXOKAY is a success response.
    push_done(128'h00000000_00000000_000000E1_000000E0, 2'd2);
    run_txn(8'h77, 32'h0000_7000, 4'd1, 0, 1, -1, 0, 2'b01, 32'hE0, 32'h1, 1);

    // Reset in the middle of the data phase.
    push_ar(8'h88, 32'h0000_8000, 4'd3);
    enable = 1'b1; id = 8'h88; addr = 32'h0000_8000; burst_len = 4'd3; burst_size = 3'd2;
    tick();
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    r_valid = 1'b1; r_data = 32'hF0;
    tick();
    r_data = 32'hF1;
    tick();
    r_valid = 1'b0;
    chk("mid_data", data, 128'h00000000_00000000_000000F1_000000F0);
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("abort_ar_valid", {127'd0, ar_valid}, 128'd0);
    chk("abort_r_ready", {127'd0, r_ready}, 128'd0);
    chk("abort_status", {126'd0, status}, 128'd0);
    chk("abort_data", data, 128'd0);
    tick();
    reset_n = 1'b1;
    tick();

    push_done(128'h00000000_00000000_00000000_12345678, 2'd2);
    run_txn(8'h99, 32'h0000_9000, 4'd0, 0, 0, -1, 0, 2'b00, 32'h12345678, 32'd0, 1);

    repeat (2) tick();
    chk("done_q_empty", 128'(done_q.size()), 128'd0);
    chk("ar_q_empty", 128'(ar_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
